nvdla_cdma_param_fifo: RTL and testbench
========================================

// Module: nvdla_cdma_param_fifo
// PURPOSE
//  Parametrised synchronous valid/ready FIFO for CDMA datapaths (DC/WG/IMG side buffers).
//  Registered write-side input stage, 1R1W storage, prefetched registered read output.
//  Adds runtime write limit, synchronous flush and occupancy reporting.
//  Sits between CDMA request generators and downstream consumers; one instance per stream.
// PARAMETERS
//  DATA_W  6    payload width in bits (>=1)
//  DEPTH   128  entries; power of 2, >=4
//  ADDR_W  $clog2(DEPTH)  derived, do not override
// PORTS
//  clk           in   1          core clock
//  reset         in   1          asynchronous, active-high reset
//  wr_req        in   1          write valid
//  wr_ready      out  1          write ready; handshake = wr_req && wr_ready
//  wr_data       in   DATA_W     write payload
//  rd_req        out  1          read valid
//  rd_ready      in   1          read ready; pop = rd_req && rd_ready
//  rd_data       out  DATA_W     read payload
//  flush         in   1          synchronous clear of all contents
//  wr_limit      in   ADDR_W+1   0 = DEPTH; else max occupancy before wr_ready drops
//  wr_count      out  ADDR_W+1   write-side occupancy (incl. in-flight entries)
//  hwm           out  ADDR_W+1   high-watermark of wr_count (NVDLA_PFIFO_HWM_EN only)
// BEHAVIOUR
//  Reset: wr_ready=1, rd_req=0, rd_data=0, wr_count=0, hwm=0; pointers, counters, stages 0.
//  Write: handshake in cycle N captures wr_data into input register; entry written to storage N+1.
//  wr_ready = !busy_in; held input register retries until space; input never lost/dup'd.
//  busy_next = (wr_count_next==DEPTH) || (wr_limit!=0 && wr_count_next>=wr_limit).
//  wr_limit lowered below wr_count: no data loss, wr_ready stays low until count drains below.
//  Pop seen by write side one cycle later (registered); free slot reflected in wr_count at N+1.
//  Push+pop same cycle: wr_count unchanged; wraps of wr_adr/rd_adr mod DEPTH, no bubble.
//  Latency: handshake in N on empty FIFO -> rd_req=1 in N+3 with that data.
//  Read: rd_req/rd_data hold stable while rd_req && !rd_ready; next entry prefetched so
//   back-to-back pops sustain 1 entry/cycle.
//  Empty: rd_req=0, rd_data holds last value. Full: wr_ready=0, rd path unaffected.
//  flush (priority over push/pop same cycle): next cycle all counts/pointers 0, rd_req=0,
//   input register cleared, wr_ready=1; hwm NOT cleared by flush (reset only).
//  Reset asserted mid-operation: all state returns to reset values immediately (async).
//  Counters ADDR_W+1 bits, never overflow/underflow; out-of-range states are bugs.
// CONFIGURATION
//  NVDLA_PFIFO_HWM_EN defined: hwm register updates to max(hwm, wr_count) every cycle.
//  Not defined: hwm tied to 0, no register inferred; all other behaviour identical.
// STRUCTURE
//  Package nvdla_pfifo_pkg: count/addr width function, flush/limit constants, status typedef.
//  Sub-module nvdla_pfifo_ram: 1R1W storage, DEPTH x DATA_W, registered read, read-enable.
//  Top holds write stage, write/read counters, prefetch output register, optional hwm.
// TESTING
//  Reset, write 1 entry (0x2A) at cycle 0, rd_ready=1 -> rd_req=1, rd_data=0x2A in cycle 3.
//  DEPTH=128, rd_ready=0, stream 130 writes -> wr_ready=0 after 128 accepted, wr_count=128;
//   then pop 1 -> wr_ready=1 within 2 cycles, 129th value delivered in order.
//  wr_limit=4, rd_ready=0 -> wr_count saturates at 4, wr_ready=0; set wr_limit=0 -> refills to DEPTH.
//  Full with continuous push+pop, random rd_ready, 10k words -> in-order, no loss/dup, wraps pass.
//  Occupancy 50, assert flush with wr_req and pop same cycle -> next cycle wr_count=0, rd_req=0,
//   wr_ready=1; hwm (if _EN) still 50.
//  Assert reset mid-burst -> outputs at reset values same cycle; post-release FIFO empty, usable.

Source files
------------

// File: rtl/nvdla_pfifo_pkg.sv
// Shared widths, control constants and status type for the CDMA parametrised FIFO.
package nvdla_pfifo_pkg;

    // Occupancy counters need one extra bit so that a full FIFO (DEPTH) is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam logic        FLUSH_ACTIVE = 1'b1;
    localparam int unsigned LIMIT_NONE   = 0;

    typedef struct packed {
        logic busy;
        logic in_vld;
        logic out_vld;
    } pfifo_status_t;

endpackage

// File: rtl/nvdla_cdma_param_fifo_if.sv
// Write/read handshake, flush and occupancy bundle for nvdla_cdma_param_fifo.
interface nvdla_cdma_param_fifo_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 128
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              wr_req;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              flush;
    logic [ADDR_W:0]   wr_limit;
    logic [ADDR_W:0]   wr_count;
    logic [ADDR_W:0]   hwm;

    modport master (
        output wr_req, wr_data, rd_ready, flush, wr_limit,
        input  wr_ready, rd_req, rd_data, wr_count, hwm
    );

    modport slave (
        input  wr_req, wr_data, rd_ready, flush, wr_limit,
        output wr_ready, rd_req, rd_data, wr_count, hwm
    );
endinterface

// File: rtl/nvdla_pfifo_ram.sv
// 1R1W DEPTH x DATA_W storage with registered, read-enabled output.
module nvdla_pfifo_ram #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_adr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_adr,
    output logic [DATA_W-1:0]          rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    // Output register doubles as the FIFO's prefetched read stage; it holds when rd_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_adr];
        end
    end
endmodule

// File: rtl/nvdla_cdma_param_fifo.sv
// CDMA valid/ready FIFO: registered write stage, 1R1W RAM, prefetched registered read output.
// Define NVDLA_PFIFO_HWM_EN to build the wr_count high-watermark register (else hwm = 0).
module nvdla_cdma_param_fifo
    import nvdla_pfifo_pkg::*;
#(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 128
) (
    input logic                    clk,
    input logic                    reset,
    nvdla_cdma_param_fifo_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = cnt_width(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
    localparam cnt_t NO_LIMIT = cnt_t'(LIMIT_NONE);

    pfifo_status_t     st;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] wr_adr;
    logic [ADDR_W-1:0] rd_adr;
    cnt_t              wr_count;
    cnt_t              ram_cnt;
    cnt_t              wr_count_next;
    logic              push;
    logic              pop;
    logic              ram_rd;
    logic              busy_next;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_dout;

    // wr_count spans input stage + RAM + output register, so the RAM can never overrun.
    always_comb begin
        push          = bus.wr_req && !st.busy;
        pop           = st.out_vld && bus.rd_ready;
        ram_rd        = (ram_cnt != '0) && (!st.out_vld || pop) && (bus.flush != FLUSH_ACTIVE);
        ram_wr        = st.in_vld && (bus.flush != FLUSH_ACTIVE);
        wr_count_next = wr_count + cnt_t'(push) - cnt_t'(pop);
        busy_next     = (wr_count_next == DEPTH_C) ||
                        ((bus.wr_limit != NO_LIMIT) && (wr_count_next >= bus.wr_limit));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= '0;
            in_data  <= '0;
            wr_adr   <= '0;
            rd_adr   <= '0;
            wr_count <= '0;
            ram_cnt  <= '0;
        end else if (bus.flush == FLUSH_ACTIVE) begin
            st       <= '0;
            in_data  <= '0;
            wr_adr   <= '0;
            rd_adr   <= '0;
            wr_count <= '0;
            ram_cnt  <= '0;
        end else begin
            st.busy   <= busy_next;
            st.in_vld <= push;
            if (push) begin
                in_data <= bus.wr_data;
            end
            if (st.in_vld) begin
                wr_adr <= wr_adr + ADDR_W'(1);
            end
            if (ram_rd) begin
                rd_adr <= rd_adr + ADDR_W'(1);
            end
            ram_cnt <= ram_cnt + cnt_t'(st.in_vld) - cnt_t'(ram_rd);
            if (ram_rd) begin
                st.out_vld <= 1'b1;
            end else if (pop) begin
                st.out_vld <= 1'b0;
            end
            wr_count <= wr_count_next;
        end
    end

    nvdla_pfifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (ram_wr),
        .wr_adr (wr_adr),
        .wr_data(in_data),
        .rd_en  (ram_rd),
        .rd_adr (rd_adr),
        .rd_data(ram_dout)
    );

    assign bus.wr_ready = !st.busy;
    assign bus.rd_req   = st.out_vld;
    assign bus.rd_data  = ram_dout;
    assign bus.wr_count = wr_count;

`ifdef NVDLA_PFIFO_HWM_EN
    cnt_t hwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwm_q <= '0;
        end else if (wr_count > hwm_q) begin
            hwm_q <= wr_count;
        end
    end

    assign bus.hwm = hwm_q;
`else
    assign bus.hwm = '0;
`endif
endmodule

// File: tb/tb_nvdla_cdma_param_fifo.sv
// Directed self-checking bench for nvdla_cdma_param_fifo (DATA_W=6, DEPTH=128).
module tb_nvdla_cdma_param_fifo;
    localparam int unsigned DATA_W = 6;
    localparam int unsigned DEPTH  = 128;
`ifdef NVDLA_PFIFO_HWM_EN
    localparam int unsigned HWM_AFTER_FLUSH = 50;
`else
    localparam int unsigned HWM_AFTER_FLUSH = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int unsigned checks = 0;
    int unsigned errors = 0;

    nvdla_cdma_param_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    nvdla_cdma_param_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pat(input int unsigned k);
        return 6'((k * 5 + 3) % 64);
    endfunction

    initial begin
        logic [5:0]  q[$];
        logic [31:0] exp_w;
        int unsigned accepted;
        int unsigned idx;
        int unsigned pops;
        int unsigned cyc;
        int unsigned ovf;
        logic        acc;

        reset        = 1'b1;
        bus.wr_req   = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.flush    = 1'b0;
        bus.wr_limit = '0;
        repeat (2) step();
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_rd_req",   bus.rd_req,   0);
        check("rst_rd_data",  bus.rd_data,  0);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_hwm",      bus.hwm,      0);
        reset = 1'b0;

        // Single write at cycle 0 must appear at cycle 3.
        bus.wr_req  = 1'b1;
        bus.wr_data = 6'h2A;
        check("lat_c0_wr_ready", bus.wr_ready, 1);
        step();
        bus.wr_req = 1'b0;
        check("lat_c1_rd_req",   bus.rd_req,   0);
        check("lat_c1_wr_count", bus.wr_count, 1);
        step();
        check("lat_c2_rd_req", bus.rd_req, 0);
        step();
        check("lat_c3_rd_req",  bus.rd_req,  1);
        check("lat_c3_rd_data", bus.rd_data, 32'h2A);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check("lat_c4_rd_req",   bus.rd_req,   0);
        check("lat_c4_wr_count", bus.wr_count, 0);
        check("lat_c4_rd_hold",  bus.rd_data,  32'h2A);

        // Stream writes into a stalled FIFO until it fills.
        accepted = 0;
        for (int c = 0; c < 140; c++) begin
            bus.wr_req  = 1'b1;
            bus.wr_data = pat(accepted);
            acc = bus.wr_ready;
            step();
            if (acc) accepted++;
        end
        bus.wr_req = 1'b0;
        check("full_accepted", accepted, 128);
        check("full_wr_count", bus.wr_count, 128);
        check("full_wr_ready", bus.wr_ready, 0);
        check("full_rd_req",   bus.rd_req,   1);
        check("full_head",     bus.rd_data,  pat(0));
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        for (int w = 0; w < 2 && !bus.wr_ready; w++) step();
        check("full_reopen_wr_ready", bus.wr_ready, 1);
        bus.wr_req  = 1'b1;
        bus.wr_data = pat(128);
        step();
        bus.wr_req = 1'b0;
        check("full_refill_count", bus.wr_count, 128);
        bus.rd_ready = 1'b1;
        idx = 1;
        for (int c = 0; c < 400 && idx <= 128; c++) begin
            if (bus.rd_req) begin
                check("full_drain_data", bus.rd_data, pat(idx));
                idx++;
            end
            step();
        end
        bus.rd_ready = 1'b0;
        check("full_drain_total", idx, 129);
        step();
        check("full_empty_rd_req", bus.rd_req,   0);
        check("full_empty_count",  bus.wr_count, 0);

        // Runtime write limit, then unlimited refill.
        bus.wr_limit = 4;
        bus.wr_req   = 1'b1;
        bus.wr_data  = 6'h11;
        repeat (10) step();
        check("lim4_wr_count", bus.wr_count, 4);
        check("lim4_wr_ready", bus.wr_ready, 0);
        bus.wr_limit = 0;
        repeat (140) step();
        check("lim0_wr_count", bus.wr_count, 128);
        check("lim0_wr_ready", bus.wr_ready, 0);
        bus.wr_req = 1'b0;
        bus.flush  = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_full_count",    bus.wr_count, 0);
        check("flush_full_rd_req",   bus.rd_req,   0);
        check("flush_full_wr_ready", bus.wr_ready, 1);

        // Fill, then continuous push with random pops against a scoreboard.
        for (int c = 0; c < 200; c++) begin
            bus.wr_req  = 1'b1;
            bus.wr_data = 6'($urandom);
            if (bus.wr_ready) q.push_back(bus.wr_data);
            step();
        end
        check("rand_fill_count", bus.wr_count, 128);
        pops = 0;
        cyc  = 0;
        ovf  = 0;
        while (pops < 10000 && cyc < 40000) begin
            bus.wr_req   = 1'b1;
            bus.wr_data  = 6'($urandom);
            bus.rd_ready = 1'($urandom_range(0, 1));
            if (bus.wr_ready) q.push_back(bus.wr_data);
            if (bus.rd_req && bus.rd_ready) begin
                exp_w = (q.size() != 0) ? {26'b0, q.pop_front()} : 32'hDEAD_BEEF;
                check("rand_data", bus.rd_data, exp_w);
                pops++;
            end
            if (bus.wr_count > 128) ovf++;
            step();
            cyc++;
        end
        bus.wr_req   = 1'b0;
        bus.rd_ready = 1'b1;
        check("rand_pops",     pops, 10000);
        check("rand_overflow", ovf,  0);
        for (int c = 0; c < 300; c++) begin
            if (bus.rd_req) begin
                exp_w = (q.size() != 0) ? {26'b0, q.pop_front()} : 32'hDEAD_BEEF;
                check("rand_drain_data", bus.rd_data, exp_w);
            end
            step();
        end
        bus.rd_ready = 1'b0;
        check("rand_model_empty", q.size(), 0);
        check("rand_rd_req_idle", bus.rd_req, 0);

        // Flush at occupancy 50 together with push and pop.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.wr_req = 1'b1;
        for (int c = 0; c < 50; c++) begin
            bus.wr_data = pat(c);
            step();
        end
        bus.wr_req = 1'b0;
        repeat (3) step();
        check("fl50_wr_count", bus.wr_count, 50);
        check("fl50_rd_req",   bus.rd_req,   1);
        bus.flush    = 1'b1;
        bus.wr_req   = 1'b1;
        bus.wr_data  = 6'h3F;
        bus.rd_ready = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.wr_req   = 1'b0;
        bus.rd_ready = 1'b0;
        check("fl50_post_count",    bus.wr_count, 0);
        check("fl50_post_rd_req",   bus.rd_req,   0);
        check("fl50_post_wr_ready", bus.wr_ready, 1);
        check("fl50_post_hwm",      bus.hwm,      HWM_AFTER_FLUSH);
        repeat (3) step();
        check("fl50_settle_rd_req", bus.rd_req,   0);
        check("fl50_settle_count",  bus.wr_count, 0);

        // Asynchronous reset in the middle of a burst.
        bus.wr_req   = 1'b1;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.wr_data = pat(c + 7);
            step();
        end
        check("burst_rd_req", bus.rd_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_wr_ready", bus.wr_ready, 1);
        check("arst_rd_req",   bus.rd_req,   0);
        check("arst_rd_data",  bus.rd_data,  0);
        check("arst_wr_count", bus.wr_count, 0);
        check("arst_hwm",      bus.hwm,      0);
        #2;
        reset        = 1'b0;
        bus.wr_req   = 1'b0;
        bus.rd_ready = 1'b0;
        step();
        check("arst_post_count",  bus.wr_count, 0);
        check("arst_post_rd_req", bus.rd_req,   0);
        bus.wr_req  = 1'b1;
        bus.wr_data = 6'h15;
        step();
        bus.wr_req = 1'b0;
        step();
        step();
        check("arst_reuse_rd_req",  bus.rd_req,  1);
        check("arst_reuse_rd_data", bus.rd_data, 32'h15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
